modred_dispatch: RTL and testbench
==================================

Name: modred_dispatch

Overview:
Initiator-side front end for the serialized shift-add modular reducer (x mod m). Accepts operand pairs on a valid/ready stream and derives the modulus bit length. Issues one-cycle start pulses to the reducer core, waits for its valid strobe, and presents results on a valid/ready output stream. Trivial cases (x < m, m == 0) are resolved locally without invoking the core.

Parameters:
WIDTH, 64, operand/result width in bits
TIMEOUT_CYCLES, 256, WAIT-state watchdog limit (used only with MODRED_DISPATCH_TIMEOUT_EN)
CNT_W, 16, width of the statistics counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active high
in_valid_i  in  1  operand pair valid
in_ready_o  out  1  dispatcher can accept a pair
in_x_i  in  WIDTH  dividend x
in_m_i  in  WIDTH  modulus m
core_start_o  out  1  one-cycle start pulse to reducer
core_x_o  out  WIDTH  x to core; stable ISSUE..WAIT
core_m_o  out  WIDTH  m to core; stable ISSUE..WAIT
core_m_bl_o  out  WIDTH  ceil(log2(m)) to core; stable ISSUE..WAIT
core_result_i  in  WIDTH  core result
core_valid_i  in  1  core result valid strobe
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts result
out_result_o  out  WIDTH  x mod m
out_err_o  out  1  result is an error (m == 0 or timeout); qualified by out_valid_o
busy_o  out  1  state != IDLE
timeout_o  out  1  sticky watchdog flag
issued_cnt_o  out  CNT_W  count of core invocations, wraps at 2^CNT_W
bypass_cnt_o  out  CNT_W  count of locally resolved requests, wraps

Behaviour:
- Reset (synchronous, rst_i=1 at posedge): state IDLE; all outputs 0, except in_ready_o=1 after reset is released. Counters and timeout_o cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: in_ready_o=1. On in_valid_i, register x and m, then:
  - m == 0: go to RESP with result 0 and err=1. bypass_cnt +1.
  - x < m (unsigned): go to RESP with result x and err=0. bypass_cnt +1.
  - otherwise: go to ISSUE.
- ISSUE: exactly one cycle. core_start_o=1; core_m_bl_o = $clog2(m) semantics (m=1 -> 0, m=2 -> 1, m=0x80000001 -> 32), computed from the registered m. issued_cnt +1. Go to WAIT. core_valid_i is ignored in ISSUE, because it may be stale from the previous job.
- WAIT: on core_valid_i, capture core_result_i with err=0 and go to RESP. core_valid_i is ignored in every state other than WAIT.
- RESP: out_valid_o=1. out_result_o and out_err_o are held stable until out_ready_i.
  - in_ready_o = out_ready_i, allowing a back-to-back accept.
  - On out_ready_i & in_valid_i, the new pair is registered and classified exactly as in IDLE in the same cycle.
  - On out_ready_i without in_valid_i, go to IDLE.
- Latency (accept edge = cycle 0):
  - bypass: out_valid_o high at cycle 1.
  - core path: start at cycle 1; out_valid_o high 1 cycle after the core_valid_i edge.
- core_x_o, core_m_o, core_m_bl_o hold their last values outside ISSUE/WAIT; core_start_o is never high for more than 1 cycle.
- Reset mid-operation: returns to IDLE immediately. Any later core_valid_i from the aborted job is ignored.
- Counters wrap silently.

Optional Feature:
MODRED_DISPATCH_TIMEOUT_EN
- Defined:
  - A WAIT cycle counter starts at 0 on WAIT entry.
  - If it reaches TIMEOUT_CYCLES without core_valid_i, go to RESP with result 0 and err=1, and set timeout_o (sticky until reset).
  - If core_valid_i arrives in the same cycle as expiry, core_valid_i wins.
- Undefined: WAIT lasts indefinitely; timeout_o is tied 0; the counter logic is absent.

Test Plan:
1. x=0x1, m=0x80000001 -> out_valid_o at cycle 1, result 0x1, err=0, no core_start_o pulse, bypass_cnt=1.
2. x=0x100000000, m=0x80000001, stub core answers 0x7FFFFFFF 5 cycles after start -> single start pulse, core_m_bl_o=32, out_result_o=0x7FFFFFFF, issued_cnt=1.
3. x=0x1234, m=0 -> out_valid_o at cycle 1, result 0, out_err_o=1, no start pulse.
4. out_ready_i low 10 cycles during RESP -> out_result_o stable, in_ready_o=0. Then out_ready_i=1 with in_valid_i=1 (x=5, m=3) -> accepted the same cycle, next result 2 via the core path.
5. rst_i asserted in WAIT, stub core_valid_i fires 3 cycles after reset release -> all outputs 0 after reset, in_ready_o=1, no out_valid_o produced.
6. With macro, TIMEOUT_CYCLES=16, stub never answers -> out_valid_o with err=1, result 0 on the 17th cycle after WAIT entry; timeout_o stays 1 through subsequent jobs.

Source files
------------

// File: rtl/modred_dispatch.sv
// -----------------------------------------------------------------------------
// modred_dispatch
//
// Initiator-side front end for the serialized shift-add modular reducer
// (x mod m). Operand pairs arrive on a valid/ready stream. Trivial cases
// (m == 0, x < m) are answered locally. Every other pair is handed to the
// reducer core with a one-cycle start pulse, and the core's strobed result is
// returned on a valid/ready output stream.
//
// Optional build macro:
//   MODRED_DISPATCH_TIMEOUT_EN - adds a WAIT-state watchdog. After
//   TIMEOUT_CYCLES WAIT cycles without a core answer, the job completes with
//   result 0, err=1, and the sticky timeout_o flag is set. If the macro is
//   undefined, WAIT lasts until the core answers and timeout_o is tied 0.
//
// Parameters:
//   WIDTH          operand/result width
//   TIMEOUT_CYCLES watchdog limit (macro builds only)
//   CNT_W          statistics counter width
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   in_valid_i/in_ready_o             operand stream handshake
//   in_x_i, in_m_i                    dividend and modulus
//   core_start_o                      one-cycle start pulse to the core
//   core_x_o, core_m_o, core_m_bl_o   core operands plus ceil(log2(m)); these
//                                     hold their value until the next issue
//   core_result_i, core_valid_i       core answer and its strobe
//   out_valid_o/out_ready_i           result stream handshake
//   out_result_o, out_err_o           x mod m; error for m == 0 or a timeout
//   busy_o                            dispatcher not idle
//   timeout_o                         sticky watchdog flag
//   issued_cnt_o, bypass_cnt_o        wrapping core and local-resolve counts
// -----------------------------------------------------------------------------
module modred_dispatch #(
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_x_i,
    input  logic [WIDTH-1:0] in_m_i,
    output logic             core_start_o,
    output logic [WIDTH-1:0] core_x_o,
    output logic [WIDTH-1:0] core_m_o,
    output logic [WIDTH-1:0] core_m_bl_o,
    input  logic [WIDTH-1:0] core_result_i,
    input  logic             core_valid_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_result_o,
    output logic             out_err_o,
    output logic             busy_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] issued_cnt_o,
    output logic [CNT_W-1:0] bypass_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] core_x;
    logic [WIDTH-1:0] core_m;
    logic [WIDTH-1:0] result;
    logic             err;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] bypass_cnt;

    logic             in_ready;
    logic             accept;
    logic             capture;
    logic             expire;
    logic             wait_expired;
    logic             m_zero;
    logic             x_below;

    // Bit length of (m - 1) equals ceil(log2(m)) for m >= 1. m == 0 maps to
    // 0, which is also the value that reset leaves on the port.
    function automatic logic [WIDTH-1:0] clog2_of(input logic [WIDTH-1:0] m);
        logic [WIDTH-1:0] m_minus1;
        logic [WIDTH-1:0] bits;
        m_minus1 = m - WIDTH'(1);
        bits     = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (m_minus1[i]) begin
                bits = WIDTH'(i + 1);
            end
        end
        if (m == '0) begin
            bits = '0;
        end
        return bits;
    endfunction

    assign m_zero  = (in_m_i == '0);
    assign x_below = (in_x_i < in_m_i);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and handshake decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        accept       = 1'b0;
        capture      = 1'b0;
        expire       = 1'b0;
        core_start_o = 1'b0;
        out_valid_o  = 1'b0;
        busy_o       = 1'b1;

        case (state)
            ST_IDLE: begin
                busy_o   = 1'b0;
                in_ready = 1'b1;
                accept   = in_valid_i;
            end
            ST_ISSUE: begin
                // A core_valid_i seen here may be left over from the previous
                // job, so it is deliberately not looked at.
                core_start_o = 1'b1;
                state_next   = ST_WAIT;
            end
            ST_WAIT: begin
                // The core answer has priority over a watchdog expiry that
                // happens in the same cycle.
                if (core_valid_i) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end else if (wait_expired) begin
                    expire     = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                out_valid_o = 1'b1;
                in_ready    = out_ready_i;
                if (out_ready_i) begin
                    if (in_valid_i) begin
                        accept = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // An accepted pair is classified the same way from IDLE and from the
        // back-to-back path in RESP.
        if (accept) begin
            state_next = (m_zero || x_below) ? ST_RESP : ST_ISSUE;
        end
    end

    // Hold off acceptance while reset is asserted.
    assign in_ready_o = in_ready & ~rst_i;

    // ------------------------------------------------------------------------
    // Datapath and statistics
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            core_x     <= '0;
            core_m     <= '0;
            result     <= '0;
            err        <= 1'b0;
            issued_cnt <= '0;
            bypass_cnt <= '0;
        end else begin
            if (accept) begin
                if (m_zero) begin
                    result     <= '0;
                    err        <= 1'b1;
                    bypass_cnt <= bypass_cnt + CNT_W'(1);
                end else if (x_below) begin
                    result     <= in_x_i;
                    err        <= 1'b0;
                    bypass_cnt <= bypass_cnt + CNT_W'(1);
                end else begin
                    // Core operands load only on the core path, so they keep
                    // their last values across bypassed requests.
                    core_x <= in_x_i;
                    core_m <= in_m_i;
                end
            end

            if (state == ST_ISSUE) begin
                issued_cnt <= issued_cnt + CNT_W'(1);
            end

            if (capture) begin
                result <= core_result_i;
                err    <= 1'b0;
            end

            if (expire) begin
                result <= '0;
                err    <= 1'b1;
            end
        end
    end

`ifdef MODRED_DISPATCH_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_flag;

    // wait_cnt is 0 in the first WAIT cycle and counts up once per WAIT cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (expire) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES));
    assign timeout_o    = timeout_flag;
`else
    assign wait_expired = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign core_x_o     = core_x;
    assign core_m_o     = core_m;
    assign core_m_bl_o  = clog2_of(core_m);
    assign out_result_o = result;
    assign out_err_o    = err;
    assign issued_cnt_o = issued_cnt;
    assign bypass_cnt_o = bypass_cnt;

endmodule

// File: tb/tb_modred_dispatch.sv
// -----------------------------------------------------------------------------
// Testbench for modred_dispatch. The bench runs directed scenarios first and
// then randomized traffic. A stub reducer core answers each start pulse. A
// transaction-level reference model predicts every result the DUT returns.
// -----------------------------------------------------------------------------
module tb_modred_dispatch;

    localparam int unsigned W = 64;
`ifdef MODRED_DISPATCH_TIMEOUT_EN
    localparam int unsigned TB_TO = 16;
`else
    localparam int unsigned TB_TO = 256;
`endif

    logic          clk_i;
    logic          rst_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [W-1:0]  in_x_i;
    logic [W-1:0]  in_m_i;
    logic          core_start_o;
    logic [W-1:0]  core_x_o;
    logic [W-1:0]  core_m_o;
    logic [W-1:0]  core_m_bl_o;
    logic [W-1:0]  core_result_i;
    logic          core_valid_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [W-1:0]  out_result_o;
    logic          out_err_o;
    logic          busy_o;
    logic          timeout_o;
    logic [15:0]   issued_cnt_o;
    logic [15:0]   bypass_cnt_o;

    modred_dispatch #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TB_TO),
        .CNT_W          (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_x_i        (in_x_i),
        .in_m_i        (in_m_i),
        .core_start_o  (core_start_o),
        .core_x_o      (core_x_o),
        .core_m_o      (core_m_o),
        .core_m_bl_o   (core_m_bl_o),
        .core_result_i (core_result_i),
        .core_valid_i  (core_valid_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_result_o  (out_result_o),
        .out_err_o     (out_err_o),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o),
        .issued_cnt_o  (issued_cnt_o),
        .bypass_cnt_o  (bypass_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: expected responses and expected core jobs, in order.
    // ------------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] m;
    } pair_t;

    exp_t  exp_q[$];
    pair_t core_q[$];
    int    exp_bypass = 0;
    int    exp_issued = 0;
    int    n_acc      = 0;
    logic  acc_flag   = 1'b0;
    logic  expect_to  = 1'b0;
    logic  hold_prev  = 1'b0;
    logic [W-1:0] prev_res;
    logic  prev_err;

    // Smallest b with 2^b >= m (0 for m <= 1).
    function automatic logic [W-1:0] ref_clog2(input logic [W-1:0] m);
        logic [W:0]  p;
        int unsigned b;
        p = 1;
        b = 0;
        while (p < {1'b0, m}) begin
            p = p << 1;
            b++;
        end
        return W'(b);
    endfunction

    // Handshake monitor at the falling edge, where inputs and outputs are
    // settled for the coming rising edge.
    always @(negedge clk_i) begin
        exp_t  e;
        pair_t p;
        acc_flag = 1'b0;
        if (rst_i) begin
            exp_q.delete();
            core_q.delete();
            exp_bypass = 0;
            exp_issued = 0;
            hold_prev  = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", out_valid_o, 1'b1);
                check("hold_result", out_result_o, prev_res);
                check("hold_err", out_err_o, prev_err);
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_result", out_result_o, e.res);
                    check("out_err", out_err_o, e.err);
                end
            end
            if (in_valid_i && in_ready_o) begin
                acc_flag = 1'b1;
                n_acc++;
                if (in_m_i == 0 || in_x_i < in_m_i) begin
                    e.res = (in_m_i == 0) ? '0 : in_x_i % in_m_i;
                    e.err = (in_m_i == 0);
                    exp_bypass++;
                end else begin
                    e.res = expect_to ? '0 : in_x_i % in_m_i;
                    e.err = expect_to;
                    p.x = in_x_i;
                    p.m = in_m_i;
                    core_q.push_back(p);
                    exp_issued++;
                end
                exp_q.push_back(e);
            end
            hold_prev = out_valid_o && !out_ready_i;
            prev_res  = out_result_o;
            prev_err  = out_err_o;
        end
    end

    // ------------------------------------------------------------------------
    // Stub reducer core
    // ------------------------------------------------------------------------
    logic         stub_en      = 1'b1;
    logic         stub_random  = 1'b0;
    logic         stub_garbage = 1'b0;
    int           stub_lat     = 5;
    int           stub_cnt     = 0;
    int           starts       = 0;
    logic [W-1:0] stub_res     = '0;
    logic         prev_start   = 1'b0;

    initial begin
        pair_t p;
        core_valid_i  = 1'b0;
        core_result_i = '0;
        forever begin
            @(posedge clk_i);
            #2;
            core_valid_i = 1'b0;
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    core_valid_i  = 1'b1;
                    core_result_i = stub_res;
                end
            end
            if (core_start_o) begin
                starts++;
                check("start_1cyc", prev_start, 1'b0);
                if (core_q.size() == 0) begin
                    check("unexpected_start", 1'b1, 1'b0);
                    p.x = '0;
                    p.m = '1;
                end else begin
                    p = core_q.pop_front();
                    check("core_x", core_x_o, p.x);
                    check("core_m", core_m_o, p.m);
                    check("core_m_bl", core_m_bl_o, ref_clog2(p.m));
                end
                if (stub_en) begin
                    stub_cnt = stub_random ? int'($urandom_range(1, 6)) : stub_lat;
                    stub_res = p.x % p.m;
                end
                // A stale strobe during the start cycle must be ignored.
                if (stub_garbage && $urandom_range(0, 3) == 0) begin
                    core_valid_i  = 1'b1;
                    core_result_i = 64'hDEAD_BEEF_0BAD_F00D;
                end
            end
            prev_start = core_start_o;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_out(input int max, output int n);
        n = 0;
        while (!out_valid_o && n < max) begin
            tick();
            n++;
        end
        if (!out_valid_o) begin
            check("wait_out_bound", 1'b0, 1'b1);
        end
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] m);
        in_x_i     = x;
        in_m_i     = m;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic drain_one();
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic rand_pair(output logic [W-1:0] x, output logic [W-1:0] m);
        case ($urandom_range(0, 4))
            0: m = '0;
            1: m = W'($urandom_range(1, 20));
            2: m = {$urandom, $urandom};
            3: m = {32'h0, $urandom};
            default: m = 64'h1 << $urandom_range(0, 63);
        endcase
        case ($urandom_range(0, 4))
            0: x = W'($urandom_range(0, 50));
            1: x = {$urandom, $urandom};
            2: x = m;
            3: x = m - 1;
            default: x = m + W'($urandom_range(0, 5));
        endcase
    endtask

    initial begin
        int n;
        int s0;
        int target;
        logic [W-1:0] rx;
        logic [W-1:0] rm;

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        in_x_i      = '0;
        in_m_i      = '0;
        out_ready_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        // Reset state
        check("rst_in_ready", in_ready_o, 1'b1);
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_start", core_start_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_timeout", timeout_o, 1'b0);
        check("rst_issued", issued_cnt_o, 16'd0);
        check("rst_bypass", bypass_cnt_o, 16'd0);
        check("rst_core_x", core_x_o, 64'd0);
        check("rst_core_m", core_m_o, 64'd0);
        check("rst_m_bl", core_m_bl_o, 64'd0);
        check("rst_result", out_result_o, 64'd0);
        check("rst_err", out_err_o, 1'b0);

        // 1: x < m bypass
        s0 = starts;
        send(64'h1, 64'h8000_0001);
        check("t1_valid", out_valid_o, 1'b1);
        check("t1_result", out_result_o, 64'h1);
        check("t1_err", out_err_o, 1'b0);
        check("t1_bypass_cnt", bypass_cnt_o, 16'd1);
        drain_one();
        check("t1_no_start", starts - s0, 0);
        check("t1_idle", busy_o, 1'b0);

        // 2: core path with a 5-cycle core
        s0 = starts;
        send(64'h1_0000_0000, 64'h8000_0001);
        check("t2_start", core_start_o, 1'b1);
        check("t2_m_bl", core_m_bl_o, 64'd32);
        wait_out(50, n);
        check("t2_latency", n, 6);
        check("t2_result", out_result_o, 64'h7FFF_FFFF);
        check("t2_err", out_err_o, 1'b0);
        check("t2_issued", issued_cnt_o, 16'd1);
        check("t2_one_start", starts - s0, 1);
        drain_one();
        check("t2_m_bl_hold", core_m_bl_o, 64'd32);

        // 3: m == 0, then 4: held response and back-to-back accept
        s0 = starts;
        send(64'h1234, 64'h0);
        check("t3_valid", out_valid_o, 1'b1);
        check("t3_result", out_result_o, 64'h0);
        check("t3_err", out_err_o, 1'b1);
        in_x_i     = 64'd5;
        in_m_i     = 64'd3;
        in_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_valid", out_valid_o, 1'b1);
            check("t4_hold_result", out_result_o, 64'h0);
            check("t4_in_ready", in_ready_o, 1'b0);
        end
        check("t3_no_start", starts - s0, 0);
        out_ready_i = 1'b1;
        #1;
        check("t4_in_ready_b2b", in_ready_o, 1'b1);
        tick();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        check("t4_start", core_start_o, 1'b1);
        check("t4_m_bl", core_m_bl_o, 64'd2);
        wait_out(50, n);
        check("t4_result", out_result_o, 64'd2);
        check("t4_err", out_err_o, 1'b0);
        drain_one();
        check("t4_bypass_cnt", bypass_cnt_o, 16'd2);

        // 5: reset in WAIT, the stale core answer arrives after release
        stub_lat = 8;
        send(64'd10, 64'd3);
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        check("t5_in_ready", in_ready_o, 1'b1);
        check("t5_core_x", core_x_o, 64'd0);
        check("t5_core_m", core_m_o, 64'd0);
        check("t5_result", out_result_o, 64'd0);
        check("t5_issued", issued_cnt_o, 16'd0);
        check("t5_bypass", bypass_cnt_o, 16'd0);
        for (int i = 0; i < 8; i++) begin
            check("t5_no_valid", out_valid_o, 1'b0);
            check("t5_idle", busy_o, 1'b0);
            check("t5_no_start", core_start_o, 1'b0);
            tick();
        end
        stub_lat = 5;

`ifdef MODRED_DISPATCH_TIMEOUT_EN
        // 6: core never answers
        stub_en   = 1'b0;
        expect_to = 1'b1;
        send(64'd7, 64'd2);
        expect_to = 1'b0;
        tick();
        wait_out(60, n);
        check("t6_latency", n, 17);
        check("t6_result", out_result_o, 64'd0);
        check("t6_err", out_err_o, 1'b1);
        check("t6_timeout", timeout_o, 1'b1);
        drain_one();
        stub_en = 1'b1;
`endif

        // Randomized traffic
        stub_random  = 1'b1;
        stub_garbage = 1'b1;
        target       = n_acc + 300;
        for (int cyc = 0; cyc < 8000 && n_acc < target; cyc++) begin
            if (!in_valid_i || acc_flag) begin
                in_valid_i = ($urandom_range(0, 9) < 6);
                rand_pair(rx, rm);
                in_x_i = rx;
                in_m_i = rm;
            end
            out_ready_i = ($urandom_range(0, 9) < 7);
            tick();
        end
        if (n_acc < target) begin
            check("rand_progress", n_acc, target);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || busy_o); i++) begin
            tick();
        end
        check("drain_empty", exp_q.size(), 0);
        check("drain_idle", busy_o, 1'b0);
        check("end_issued", issued_cnt_o, exp_issued[15:0]);
        check("end_bypass", bypass_cnt_o, exp_bypass[15:0]);
`ifdef MODRED_DISPATCH_TIMEOUT_EN
        check("end_timeout_sticky", timeout_o, 1'b1);
`else
        check("end_timeout_tied", timeout_o, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
